cordic_arbiter: RTL

CORDIC_ARBITER -- requirements
Module: cordic_arbiter

---
 rtl/cordic_arbiter_if.sv | 42 ++++
 rtl/cordic_arbiter.sv | 94 +++++++++
 2 files changed

// File: rtl/cordic_arbiter_if.sv
// rtl/cordic_arbiter_if.sv - requester, engine and response signals of the CORDIC arbiter
interface cordic_arbiter_if #(
  parameter int WIDTH   = 64,
  parameter int MAX_OUT = 16
);
  localparam int CW = $clog2(MAX_OUT) + 1;

  logic             req0_valid, req1_valid;
  logic             req0_ready, req1_ready;
  logic [WIDTH-1:0] req0_x, req0_y, req0_z;
  logic [WIDTH-1:0] req1_x, req1_y, req1_z;
  logic             req0_mode, req1_mode;

  logic             eng_valid_in;
  logic [WIDTH-1:0] eng_x, eng_y, eng_z;
  logic             eng_mode;

  logic             eng_valid_out;
  logic [WIDTH-1:0] eng_cos, eng_sin, eng_tan_in;

  logic             rsp0_valid, rsp1_valid;
  logic [WIDTH-1:0] rsp_cos, rsp_sin, rsp_tan_in;

  logic [CW-1:0]    outstanding;
  logic             err_orphan;

  // arbiter side
  modport slave (
    input  req0_valid, req1_valid, req0_x, req0_y, req0_z, req1_x, req1_y, req1_z,
           req0_mode, req1_mode, eng_valid_out, eng_cos, eng_sin, eng_tan_in,
    output req0_ready, req1_ready, eng_valid_in, eng_x, eng_y, eng_z, eng_mode,
           rsp0_valid, rsp1_valid, rsp_cos, rsp_sin, rsp_tan_in, outstanding, err_orphan
  );

  // requesters plus engine side
  modport master (
    output req0_valid, req1_valid, req0_x, req0_y, req0_z, req1_x, req1_y, req1_z,
           req0_mode, req1_mode, eng_valid_out, eng_cos, eng_sin, eng_tan_in,
    input  req0_ready, req1_ready, eng_valid_in, eng_x, eng_y, eng_z, eng_mode,
           rsp0_valid, rsp1_valid, rsp_cos, rsp_sin, rsp_tan_in, outstanding, err_orphan
  );
endinterface

// File: rtl/cordic_arbiter.sv
// rtl/cordic_arbiter.sv - two-requester round-robin front end for a shared in-order CORDIC engine
module cordic_arbiter #(
  parameter int WIDTH   = 64,
  parameter int MAX_OUT = 16
) (
  input logic            clk,
  input logic            rst,
  cordic_arbiter_if.slave bus
);
  localparam int            PW   = $clog2(MAX_OUT);
  localparam int            CW   = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(MAX_OUT);

  logic [CW-1:0]      count;
  logic               last_grant;
  logic [PW-1:0]      wr_ptr, rd_ptr;
  logic [MAX_OUT-1:0] tags;
  logic               err_q;
  logic               eng_valid_q;
  logic [WIDTH-1:0]   x_q, y_q, z_q;
  logic               mode_q;

  logic credit, grant0, grant1, accept, pop, orphan, head_tag;

  // Credit is checked against the registered count only, so a same-cycle pop never frees a slot early.
  always_comb begin
    credit   = (count < FULL);
    grant0   = bus.req0_valid & credit & (~bus.req1_valid | last_grant);
    grant1   = bus.req1_valid & credit & (~bus.req0_valid | ~last_grant);
    accept   = grant0 | grant1;
    pop      = bus.eng_valid_out & (count != '0);
    orphan   = bus.eng_valid_out & (count == '0);
    head_tag = tags[rd_ptr];
  end

  // Occupancy, FIFO pointers, round-robin pointer and the sticky orphan flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count      <= '0;
      last_grant <= 1'b1;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      err_q      <= 1'b0;
    end else begin
      if (accept && !pop)      count <= count + CW'(1);
      else if (!accept && pop) count <= count - CW'(1);
      if (accept) begin
        last_grant <= grant1;
        wr_ptr     <= wr_ptr + PW'(1);
      end
      if (pop)    rd_ptr <= rd_ptr + PW'(1);
      if (orphan) err_q  <= 1'b1;
    end
  end

  // Tag storage needs no reset: entries are only read between matching push and pop.
  always_ff @(posedge clk) begin
    if (accept) tags[wr_ptr] <= grant1;
  end

  // One-cycle issue register toward the engine; operands hold when idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      eng_valid_q <= 1'b0;
      x_q         <= '0;
      y_q         <= '0;
      z_q         <= '0;
      mode_q      <= 1'b0;
    end else begin
      eng_valid_q <= accept;
      if (accept) begin
        x_q    <= grant1 ? bus.req1_x    : bus.req0_x;
        y_q    <= grant1 ? bus.req1_y    : bus.req0_y;
        z_q    <= grant1 ? bus.req1_z    : bus.req0_z;
        mode_q <= grant1 ? bus.req1_mode : bus.req0_mode;
      end
    end
  end

  assign bus.req0_ready   = grant0;
  assign bus.req1_ready   = grant1;
  assign bus.eng_valid_in = eng_valid_q;
  assign bus.eng_x        = x_q;
  assign bus.eng_y        = y_q;
  assign bus.eng_z        = z_q;
  assign bus.eng_mode     = mode_q;
  assign bus.rsp0_valid   = pop & ~head_tag;
  assign bus.rsp1_valid   = pop & head_tag;
  assign bus.rsp_cos      = bus.eng_cos;
  assign bus.rsp_sin      = bus.eng_sin;
  assign bus.rsp_tan_in   = bus.eng_tan_in;
  assign bus.outstanding  = count;
  assign bus.err_orphan   = err_q;
endmodule
